// File: rtl/pacote_isa.sv
// rtl/pacote_isa.sv - shared ISA definitions for the fetch unit: state encoding, instruction fields, halt opcode
package pacote_isa;

   localparam logic [1:0] ESTADO_INICIO = 2'd0;
   localparam logic [1:0] ESTADO_BUSCA  = 2'd1;
   localparam logic [1:0] ESTADO_PARADO = 2'd2;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int REG_A_MSB  = 26;
   localparam int REG_A_LSB  = 22;
   localparam int REG_B_MSB  = 21;
   localparam int REG_B_LSB  = 17;
   localparam int IMED_MSB   = 21;
   localparam int IMED_LSB   = 0;

   localparam logic [4:0] OPCODE_PARADA_PADRAO = 5'd31;

endpackage

// File: rtl/unidade_de_busca.sv
// rtl/unidade_de_busca.sv - instruction fetch unit with stall, redirect and halt handling
module unidade_de_busca
   import pacote_isa::*;
#(
   parameter logic [31:0] END_INICIAL   = 32'd1,
   parameter int          TAM_MEMORIA   = 21,
   parameter logic [4:0]  OPCODE_PARADA = OPCODE_PARADA_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] endereco,
   input  logic [31:0] instrucao,
   input  logic        desvio,
   input  logic [31:0] alvo_desvio,
   input  logic        decod_pronto,
   output logic        instr_valida,
   output logic [31:0] instr_reg,
   output logic [31:0] pc_reg,
   output logic [4:0]  opcode,
   output logic [4:0]  reg_a,
   output logic [4:0]  reg_b,
   output logic [21:0] imediato,
   output logic        parado
);

   localparam logic [31:0] C_TAM = 32'(TAM_MEMORIA);

   logic [1:0]  r_estado;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_instr;
   logic        r_valida;

   logic [31:0] w_alvo;
   logic [31:0] w_pc_prox;
   logic        w_e_parada;

   // Out-of-range redirect targets fall back to the start address.
   assign w_alvo     = (alvo_desvio >= C_TAM) ? END_INICIAL : alvo_desvio;
   assign w_pc_prox  = (r_pc == C_TAM - 32'd1) ? END_INICIAL : r_pc + 32'd1;
   assign w_e_parada = (instrucao[OPCODE_MSB:OPCODE_LSB] == OPCODE_PARADA);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado   <= ESTADO_INICIO;
         r_pc       <= END_INICIAL;
         r_instr    <= 32'd0;
         r_pc_instr <= 32'd0;
         r_valida   <= 1'b0;
      end else begin
         case (r_estado)
            ESTADO_INICIO: r_estado <= ESTADO_BUSCA;
            ESTADO_BUSCA: begin
               if (desvio) begin
                  r_pc     <= w_alvo;
                  r_valida <= 1'b0;
               end else if (!r_valida || decod_pronto) begin
                  r_instr    <= instrucao;
                  r_pc_instr <= r_pc;
                  r_valida   <= 1'b1;
                  r_pc       <= w_pc_prox;
                  if (w_e_parada) r_estado <= ESTADO_PARADO;
               end
            end
            ESTADO_PARADO: begin
               // Only reset leaves this state; the last instruction drains on decode.
               if (decod_pronto) r_valida <= 1'b0;
            end
            default: r_estado <= ESTADO_INICIO;
         endcase
      end
   end

   assign endereco     = r_pc;
   assign instr_valida = r_valida;
   assign instr_reg    = r_instr;
   assign pc_reg       = r_pc_instr;
   assign parado       = (r_estado == ESTADO_PARADO);
   assign opcode       = r_instr[OPCODE_MSB:OPCODE_LSB];
   assign reg_a        = r_instr[REG_A_MSB:REG_A_LSB];
   assign reg_b        = r_instr[REG_B_MSB:REG_B_LSB];
   assign imediato     = r_instr[IMED_MSB:IMED_LSB];

endmodule

// File: tb/tb_unidade_de_busca.sv
// tb/tb_unidade_de_busca.sv - self-checking bench for unidade_de_busca against a behavioural model
module tb_unidade_de_busca;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] endereco;
   logic [31:0] instrucao;
   logic        desvio = 1'b0;
   logic [31:0] alvo_desvio = 32'd0;
   logic        decod_pronto = 1'b0;
   logic        instr_valida;
   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic [4:0]  opcode;
   logic [4:0]  reg_a;
   logic [4:0]  reg_b;
   logic [21:0] imediato;
   logic        parado;

   logic [31:0] mem [0:20];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pcreg;
   bit          m_valid;
   bit          m_halt;
   bit          m_inicio;

   unidade_de_busca dut (
      .clock        (clock),
      .reset        (reset),
      .endereco     (endereco),
      .instrucao    (instrucao),
      .desvio       (desvio),
      .alvo_desvio  (alvo_desvio),
      .decod_pronto (decod_pronto),
      .instr_valida (instr_valida),
      .instr_reg    (instr_reg),
      .pc_reg       (pc_reg),
      .opcode       (opcode),
      .reg_a        (reg_a),
      .reg_b        (reg_b),
      .imediato     (imediato),
      .parado       (parado)
   );

   always #5 clock = ~clock;

   assign instrucao = (endereco < 32'd21) ? mem[endereco[4:0]] : 32'd0;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   task automatic compare_all();
      chk("endereco", endereco, m_pc);
      chk("instr_valida", 32'(instr_valida), 32'(m_valid));
      chk("parado", 32'(parado), 32'(m_halt));
      if (m_valid) begin
         chk("instr_reg", instr_reg, m_instr);
         chk("pc_reg", pc_reg, m_pcreg);
         chk("opcode", 32'(opcode), 32'(m_instr >> 27));
         chk("reg_a", 32'(reg_a), (m_instr >> 22) & 32'h1F);
         chk("reg_b", 32'(reg_b), (m_instr >> 17) & 32'h1F);
         chk("imediato", 32'(imediato), m_instr & 32'h3FFFFF);
      end
   endtask

   task automatic model_step(input bit dp, input bit dv, input logic [31:0] alvo);
      logic [31:0] w;
      if (m_inicio) begin
         m_inicio = 0;
      end else if (m_halt) begin
         if (dp) m_valid = 0;
      end else if (dv) begin
         m_pc    = (alvo >= 32'd21) ? 32'd1 : alvo;
         m_valid = 0;
      end else if (!m_valid || dp) begin
         w       = mem[m_pc[4:0]];
         m_instr = w;
         m_pcreg = m_pc;
         m_valid = 1;
         m_pc    = (m_pc == 32'd20) ? 32'd1 : m_pc + 32'd1;
         if ((w >> 27) == 32'd31) m_halt = 1;
      end
   endtask

   task automatic cyc(input bit dp, input bit dv, input logic [31:0] alvo);
      decod_pronto = dp;
      desvio       = dv;
      alvo_desvio  = alvo;
      @(negedge clock);
      compare_all();
      model_step(dp, dv, alvo);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_endereco", endereco, 32'd1);
      chk("rst_valida", 32'(instr_valida), 32'd0);
      chk("rst_instr_reg", instr_reg, 32'd0);
      chk("rst_pc_reg", pc_reg, 32'd0);
      chk("rst_parado", 32'(parado), 32'd0);
      m_pc = 32'd1; m_instr = 32'd0; m_pcreg = 32'd0;
      m_valid = 0; m_halt = 0; m_inicio = 1;
      decod_pronto = 1'b0;
      desvio = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
   endtask

   task automatic fill_random(input bit com_parada);
      logic [31:0] w;
      for (int i = 0; i < 21; i++) begin
         w = $urandom;
         w[31:27] = 5'($urandom_range(0, 30));
         mem[i] = w;
      end
      if (com_parada) mem[6] = 32'hF800_0000;
   endtask

   initial begin
      logic [31:0] v_a;
      logic [31:0] v_b;
      logic [31:0] v_c;
      logic [31:0] v_e;
      logic [31:0] v_h;
      logic [31:0] v_z;
      bit rdp;
      bit rdv;

      fill_random(1'b1);
      v_a = 32'h08C4_1234; v_b = 32'h1234_5678; v_c = 32'h7FFF_FFFF;
      v_e = 32'hA000_00A5; v_h = 32'hF800_0000; v_z = 32'h5555_AAAA;
      mem[1] = v_a; mem[2] = v_b; mem[3] = v_c; mem[5] = v_e; mem[6] = v_h; mem[20] = v_z;

      #2;
      do_reset();
      cyc(1, 1, 32'd9);
      chk("inicio_endereco", endereco, 32'd1);
      chk("inicio_valida", 32'(instr_valida), 32'd0);
      cyc(1, 0, 32'd0);
      chk("seq_a", instr_reg, v_a);
      chk("seq_a_pc", pc_reg, 32'd1);
      chk("campo_opcode", 32'(opcode), 32'd1);
      chk("campo_reg_a", 32'(reg_a), 32'd3);
      chk("campo_reg_b", 32'(reg_b), 32'd2);
      chk("campo_imediato", 32'(imediato), 32'h041234);
      cyc(1, 0, 32'd0);
      chk("seq_b", instr_reg, v_b);
      chk("seq_b_pc", pc_reg, 32'd2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 32'd0);
         chk("stall_instr", instr_reg, v_b);
         chk("stall_pc", pc_reg, 32'd2);
         chk("stall_endereco", endereco, 32'd3);
      end
      cyc(1, 1, 32'd5);
      chk("desvio_valida", 32'(instr_valida), 32'd0);
      chk("desvio_endereco", endereco, 32'd5);
      cyc(1, 0, 32'd0);
      chk("desvio_pc_reg", pc_reg, 32'd5);
      chk("desvio_instr", instr_reg, v_e);
      cyc(1, 0, 32'd0);
      chk("halt_pc_reg", pc_reg, 32'd6);
      chk("halt_instr", instr_reg, v_h);
      chk("halt_parado", 32'(parado), 32'd1);
      chk("halt_endereco", endereco, 32'd7);
      cyc(0, 1, 32'd2);
      chk("halt_ign_desvio", endereco, 32'd7);
      chk("halt_valida", 32'(instr_valida), 32'd1);
      cyc(1, 1, 32'd2);
      chk("halt_drena", 32'(instr_valida), 32'd0);
      chk("halt_parado2", 32'(parado), 32'd1);
      cyc(1, 0, 32'd0);
      chk("halt_congelado", endereco, 32'd7);

      do_reset();
      cyc(1, 0, 32'd0);
      cyc(1, 1, 32'd6);
      chk("pre_halt_endereco", endereco, 32'd6);
      cyc(1, 1, 32'd3);
      chk("desvio_vence_halt", 32'(parado), 32'd0);
      chk("desvio_vence_end", endereco, 32'd3);
      cyc(1, 0, 32'd0);
      chk("pos_desvio_instr", instr_reg, v_c);
      cyc(1, 1, 32'd20);
      chk("alvo_20", endereco, 32'd20);
      cyc(1, 0, 32'd0);
      chk("wrap_pc_reg", pc_reg, 32'd20);
      chk("wrap_instr", instr_reg, v_z);
      chk("wrap_endereco", endereco, 32'd1);
      cyc(1, 1, 32'd40);
      chk("alvo_fora", endereco, 32'd1);
      cyc(1, 0, 32'd0);
      cyc(0, 0, 32'd0);
      do_reset();

      for (int r = 0; r < 4; r++) begin
         fill_random(r != 1);
         do_reset();
         for (int c = 0; c < 300; c++) begin
            rdp = ($urandom_range(0, 3) != 0);
            rdv = ($urandom_range(0, 9) == 0);
            cyc(rdp, rdv, 32'($urandom_range(0, 40)));
            if ($urandom_range(0, 199) == 0) do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
